mem_port_arbiter: RTL and testbench

- Shares Frankie's single-port main memory between two requesters:
  - the CPU datapath, sequenced by the control unit: instruction fetch, LOAD/STOR, stack push/pop;
  - the I/O port engine.
- Sequences each access with a fixed-latency FSM and returns read data to the requester.
- Holds the CPU in a stall state while its access is pending, so the control unit need not know memory latency or contention.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (CPU / I/O) arbiter for a single-port memory with a fixed-latency access FSM.
// Ties are broken round-robin; the CPU sees a combinational stall until its done pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..4");
    end
  endgenerate

  localparam logic [1:0] LAT_TOP = 2'(MEM_LAT - 1);
  localparam logic       OWN_CPU = 1'b0;
  localparam logic       OWN_IO  = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_owner, r_last, r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [1:0]          r_cnt;
  logic [DATA_W-1:0]   r_cpu_rdata, r_io_rdata;
  logic                r_cpu_done, r_io_done;
  logic                w_grant, w_grant_io, w_last_beat;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_io = 1'b0;
    case (r_state)
      S_IDLE: if (cpu_req || io_req) begin
        w_grant    = 1'b1;
        w_grant_io = io_req & ~(cpu_req & (r_last == OWN_IO));
        w_next     = S_BUSY;
      end
      S_BUSY: if (r_cnt == 2'd0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_last_beat = (r_state == S_BUSY) && (r_cnt == 2'd0);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_owner     <= OWN_CPU;
      r_last      <= OWN_IO;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= 2'd0;
      r_cpu_rdata <= '0;
      r_io_rdata  <= '0;
      r_cpu_done  <= 1'b0;
      r_io_done   <= 1'b0;
    end else begin
      r_cpu_done <= w_last_beat && (r_owner == OWN_CPU);
      r_io_done  <= w_last_beat && (r_owner == OWN_IO);
      if (w_grant) begin
        r_owner <= w_grant_io;
        r_last  <= w_grant_io;
        r_we    <= w_grant_io ? io_we    : cpu_we;
        r_addr  <= w_grant_io ? io_addr  : cpu_addr;
        r_wdata <= w_grant_io ? io_wdata : cpu_wdata;
        r_cnt   <= LAT_TOP;
      end else if (r_state == S_BUSY && r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
      end
      if (w_last_beat && !r_we) begin
        if (r_owner == OWN_IO) r_io_rdata  <= mem_rdata;
        else                   r_cpu_rdata <= mem_rdata;
      end
    end
  end

  // Write strobe only on the first BUSY beat so a write commits exactly once.
  assign mem_en    = (r_state == S_BUSY);
  assign mem_we    = mem_en && r_we && (r_cnt == LAT_TOP);
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_rdata = r_cpu_rdata;
  assign io_rdata  = r_io_rdata;
  assign cpu_done  = r_cpu_done;
  assign io_done   = r_io_done;
  assign cpu_stall = cpu_req & ~r_cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized two-requester traffic
// against a word-level memory model; a monitor pops expectations on every done pulse.
module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;
  localparam int LIMIT   = 20;

  logic        CLK = 1'b0, Reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, io_req = 0, io_we = 0;
  logic [15:0] cpu_addr = 0, cpu_wdata = 0, io_addr = 0, io_wdata = 0;
  logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_done, cpu_stall, io_done, mem_en, mem_we;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_done(io_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  always #5 CLK = ~CLK;

  typedef struct {bit we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] rdata;} exp_t;
  exp_t        q [2][$];
  int          n_chk = 0, n_err = 0;
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] ref_rd [2];
  int          done_order [$];

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5C3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory: one registered read stage, write on mem_we.
  logic [15:0] mem [0:65535];
  initial begin
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    forever begin
      @(posedge CLK);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  // Monitor: counts write strobes per transaction and checks each done against the scoreboard.
  initial begin
    int we_cnt; logic [15:0] wa, wd; bit pc, pi; exp_t e;
    we_cnt = 0; wa = 0; wd = 0; pc = 0; pi = 0;
    forever begin
      @(negedge CLK);
      if (!Reset) begin we_cnt = 0; pc = 0; pi = 0; end
      else begin
        if (mem_en && mem_we) begin we_cnt++; wa = mem_addr; wd = mem_wdata; end
        if (cpu_done && io_done) chk("both_done", 1, 0);
        if (cpu_done && pc) chk("cpu_done_width", 2, 1);
        if (io_done && pi) chk("io_done_width", 2, 1);
        for (int r = 0; r < 2; r++) begin
          if ((r == 0) ? cpu_done : io_done) begin
            done_order.push_back(r);
            if (q[r].size() == 0) chk($sformatf("unexpected_done%0d", r), 1, 0);
            else begin
              e = q[r].pop_front();
              chk($sformatf("rdata%0d", r), (r == 0) ? cpu_rdata : io_rdata, e.rdata);
              chk($sformatf("we_count%0d", r), we_cnt, e.we ? 1 : 0);
              if (e.we) begin
                chk($sformatf("waddr%0d", r), wa, e.addr);
                chk($sformatf("wdata%0d", r), wd, e.wdata);
              end
            end
            we_cnt = 0;
          end
        end
        pc = cpu_done; pi = io_done;
      end
    end
  end

  // Issue an access for requester r and record what the memory model says it must return.
  task automatic issue(input int r, input bit we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = d;
    if (we) ref_mem[a] = d;
    else ref_rd[r] = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    e.rdata = ref_rd[r];
    q[r].push_back(e);
    if (r == 0) begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    else        begin io_req  = 1; io_we  = we; io_addr  = a; io_wdata  = d; end
  endtask

  task automatic drop(input int r);
    if (r == 0) cpu_req = 0; else io_req = 0;
  endtask

  task automatic rand_issue(input int r);
    logic [15:0] a;
    a = (r == 0 ? 16'h8000 : 16'h9000) | 16'($urandom_range(0, 15));
    issue(r, 1'($urandom_range(0, 1)), a, 16'($urandom));
  endtask

  task automatic wait_done(input int r, output int cyc);
    cyc = 0;
    forever begin
      @(negedge CLK);
      if ((r == 0) ? cpu_done : io_done) break;
      cyc++;
      if (cyc > LIMIT) begin chk($sformatf("done_timeout%0d", r), cyc, 0); break; end
    end
  endtask

  task automatic do_reset();
    Reset = 0; cpu_req = 0; io_req = 0;
    q[0].delete(); q[1].delete(); ref_rd[0] = 0; ref_rd[1] = 0;
    repeat (2) @(negedge CLK);
    Reset = 1;
    @(posedge CLK); #1;
  endtask

  initial begin
    int cyc, cnt, en_cnt, wc, tmo;
    int ndone [2]; bit pend [2]; int wcnt [2]; int rem [2]; bit d [2];
    ref_rd[0] = 0; ref_rd[1] = 0;
    do_reset();

    @(negedge CLK);
    chk("rst_outputs", {cpu_rdata, io_rdata}, 32'h0);
    chk("rst_ctl", {cpu_done, io_done, mem_en, mem_we, cpu_stall}, 0);
    chk("rst_mem_bus", {mem_addr, mem_wdata}, 32'h0);
    @(posedge CLK); #1;

    // Single CPU read: exact cycle timing.
    issue(0, 0, 16'h0040, 16'h0);
    @(negedge CLK);
    chk("t1_c0_stall_en", {cpu_stall, mem_en}, 2'b10);
    for (int c = 1; c <= MEM_LAT; c++) begin
      @(negedge CLK);
      chk("t1_busy_en_stall", {mem_en, cpu_stall, cpu_done}, 3'b110);
      chk("t1_busy_addr", mem_addr, 16'h0040);
    end
    @(negedge CLK);
    chk("t1_done_cycle", {cpu_done, cpu_stall, mem_en}, 3'b100);
    chk("t1_rdata", cpu_rdata, 16'hBEEF);
    @(posedge CLK); #1; drop(0);

    // I/O write, then CPU reads it back.
    issue(1, 1, 16'h0010, 16'h1234);
    wait_done(1, cyc);
    chk("t2_io_latency", cyc, MEM_LAT + 1);
    chk("t2_io_rdata_kept", io_rdata, 16'h0000);
    @(posedge CLK); #1; drop(1);
    issue(0, 0, 16'h0010, 16'h0);
    wait_done(0, cyc);
    chk("t2_cpu_readback", cpu_rdata, 16'h1234);
    @(posedge CLK); #1; drop(0);

    // I/O read with req dropped during BUSY.
    issue(1, 0, 16'h0020, 16'h0);
    @(posedge CLK); #1; drop(1);
    wait_done(1, cyc);
    chk("t4_latency", cyc, MEM_LAT);
    en_cnt = 0;
    repeat (6) begin @(negedge CLK); en_cnt += mem_en; end
    chk("t4_no_regrant", en_cnt, 0);
    @(posedge CLK); #1;

    // CPU write then CPU read: one IDLE cycle between transactions.
    issue(0, 1, 16'h0050, 16'h5A5A);
    wait_done(0, cyc);
    @(posedge CLK); #1;
    issue(0, 0, 16'h0060, 16'h0);
    wc = 0;
    forever begin @(negedge CLK); if (mem_en || wc > LIMIT) break; wc++; end
    chk("t6_idle_gap", wc, 1);
    wait_done(0, cyc);
    @(posedge CLK); #1; drop(0);

    // Reset in the middle of a CPU read.
    issue(0, 0, 16'h0030, 16'h0);
    @(negedge CLK); @(negedge CLK);
    chk("t5_busy_before_rst", mem_en, 1'b1);
    #2 Reset = 0;
    #1;
    chk("t5_mem_en_drop", {mem_en, mem_we}, 2'b00);
    chk("t5_cpu_rdata_cleared", cpu_rdata, 16'h0);
    chk("t5_no_done", cpu_done, 1'b0);
    do_reset();

    // Continuous contention straight after reset: CPU first, then strict alternation.
    done_order.delete();
    rand_issue(0); rand_issue(1);
    ndone[0] = 0; ndone[1] = 0; tmo = 0;
    while ((ndone[0] < 4 || ndone[1] < 4) && tmo < 200) begin
      @(negedge CLK); d[0] = cpu_done; d[1] = io_done;
      @(posedge CLK); #1; tmo++;
      for (int r = 0; r < 2; r++) if (d[r]) begin
        ndone[r]++;
        if (ndone[r] < 4) rand_issue(r); else drop(r);
      end
    end
    chk("t3_done_count", done_order.size(), 8);
    for (int i = 0; i < done_order.size() && i < 8; i++)
      chk($sformatf("t3_order%0d", i), done_order[i], i % 2);

    // Randomized traffic.
    rem[0] = 40; rem[1] = 40; pend[0] = 0; pend[1] = 0; wcnt[0] = 0; wcnt[1] = 0; tmo = 0;
    while ((rem[0] > 0 || rem[1] > 0 || pend[0] || pend[1]) && tmo < 3000) begin
      @(negedge CLK); d[0] = cpu_done; d[1] = io_done;
      @(posedge CLK); #1; tmo++;
      for (int r = 0; r < 2; r++) begin
        if (pend[r]) begin
          if (d[r]) pend[r] = 0;
          else if (++wcnt[r] > LIMIT) begin
            chk($sformatf("rand_timeout%0d", r), wcnt[r], 0);
            pend[r] = 0;
          end
        end
        if (!pend[r] && rem[r] > 0 && $urandom_range(0, 99) < 60) begin
          rand_issue(r); pend[r] = 1; rem[r]--; wcnt[r] = 0;
        end else if (!pend[r]) drop(r);
      end
    end
    repeat (8) @(negedge CLK);
    cnt = q[0].size() + q[1].size();
    chk("scoreboard_drained", cnt, 0);
    chk("rand_finished", tmo < 3000, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
